// File: rtl/serializer_ddr_stream.sv
// serializer_ddr_stream: double-buffered parallel-to-serial engine emitting SDR/DDR bit groups per lane
// plus a clock lane, filling empty word slots with an idle or repeated word.
module serializer_ddr_stream #(
    parameter int NUM_CHANNELS = 3,
    parameter int WORD_WIDTH = 10,
    parameter bit DDR = 1'b1,
    parameter bit LSB_FIRST = 1'b1,
    parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN = 10'b0000011111,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD = 10'b1101010100,
    parameter bit REPEAT_ON_UNDERRUN = 1'b0,
    localparam int B = DDR ? 2 : 1,
    localparam int N = WORD_WIDTH / B
) (
    input  logic                               clk_pixel_x5,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_CHANNELS*B-1:0]          ser_out,
    output logic [B-1:0]                       ser_clock,
    output logic                               word_start,
    output logic                               underrun,
    output logic [15:0]                        underrun_count
);
    localparam int SW = $clog2(N);

    if (WORD_WIDTH % B != 0 || N < 2) begin : g_bad_cfg
        $error("serializer_ddr_stream: WORD_WIDTH must split into at least two groups of B bits");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                                   state, state_n;
    logic [SW-1:0]                            slot, slot_n;
    logic [NUM_CHANNELS*WORD_WIDTH-1:0]       hold, hold_n;
    logic                                     hold_valid, hold_valid_n;
    logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0]  last, last_n, shift, shift_n;
    logic [WORD_WIDTH-1:0]                    cshift, cshift_n;
    logic [NUM_CHANNELS*B-1:0]                ser_out_n;
    logic [B-1:0]                             ser_clock_n;
    logic [15:0]                              count_n;
    logic                                     load, stop, fill;

    // Shift registers hold words in transmit order so the next group is always at the bottom.
    function automatic logic [WORD_WIDTH-1:0] order(input logic [WORD_WIDTH-1:0] w);
        for (int i = 0; i < WORD_WIDTH; i++) order[i] = LSB_FIRST ? w[i] : w[WORD_WIDTH-1-i];
    endfunction

    always_comb begin
        load = state == IDLE ? (enable && hold_valid) : (slot == SW'(N-1) && enable);
        stop = state == RUN && slot == SW'(N-1) && !enable;
        fill = load && !hold_valid;
        state_n = load ? RUN : stop ? IDLE : state;
        slot_n = (state == RUN && !load && !stop) ? slot + 1'b1 : '0;
        hold_n = (in_valid && in_ready) ? in_data : hold;
        hold_valid_n = (in_valid && in_ready) || (hold_valid && !load);
        last_n = (load && hold_valid) ? hold : last;
        cshift_n = load ? order(CLOCK_PATTERN) : state == RUN ? cshift >> B : cshift;
        shift_n = shift;
        ser_out_n = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            shift_n[c] = load ? order(hold_valid ? hold[c*WORD_WIDTH +: WORD_WIDTH] :
                                      REPEAT_ON_UNDERRUN ? last[c] : IDLE_WORD) :
                         state == RUN ? shift[c] >> B : shift[c];
            ser_out_n[c*B +: B] = state_n == RUN ? shift_n[c][B-1:0] : '0;
        end
        ser_clock_n = state_n == RUN ? cshift_n[B-1:0] : '0;
        count_n = (fill && underrun_count != 16'hFFFF) ? underrun_count + 16'd1 : underrun_count;
    end

    always_ff @(posedge clk_pixel_x5 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            slot           <= '0;
            hold           <= '0;
            hold_valid     <= 1'b0;
            last           <= {NUM_CHANNELS{IDLE_WORD}};
            shift          <= '0;
            cshift         <= '0;
            ser_out        <= '0;
            ser_clock      <= '0;
            word_start     <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            state          <= state_n;
            slot           <= slot_n;
            hold           <= hold_n;
            hold_valid     <= hold_valid_n;
            last           <= last_n;
            shift          <= shift_n;
            cshift         <= cshift_n;
            ser_out        <= ser_out_n;
            ser_clock      <= ser_clock_n;
            word_start     <= load;
            underrun       <= fill;
            underrun_count <= count_n;
        end
    end

    assign in_ready = !hold_valid;
endmodule

// File: tb/tb_serializer_ddr_stream.sv
// tb_serializer_ddr_stream: directed scoreboard bench for a default DDR instance and an
// 8-bit SDR MSB-first instance with repeat-on-underrun.
module tb_serializer_ddr_stream;
    typedef struct packed {logic [5:0] so; logic [1:0] sc; logic ws;} beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_en = 1'b0, a_val = 1'b0;
    logic [29:0] a_din = '0;
    logic        a_rdy, a_ws, a_ur;
    logic [5:0]  a_so;
    logic [1:0]  a_sc;
    logic [15:0] a_ucnt;
    logic        b_en = 1'b0, b_val = 1'b0;
    logic [7:0]  b_din = '0;
    logic        b_rdy, b_ws, b_ur;
    logic [0:0]  b_so, b_sc;
    logic [15:0] b_ucnt;

    logic [9:0]  cp = 10'b0000011111;
    logic [9:0]  idle_w = 10'b1101010100;
    logic [9:0]  t1_so = 10'b00_01_01_01_11;
    logic [9:0]  t1_sc = 10'b11_11_01_00_00;
    logic [7:0]  b_seq = 8'hA5;
    logic [7:0]  b_cseq = 8'b00001111;

    beat_t qa[$];
    int total = 0, bad = 0, a_left = 0, a_upulse = 0, lowrun = 0, maxrun = 0;
    bit track = 1'b0;

    always #5 clk = ~clk;

    serializer_ddr_stream dut_a (
        .clk_pixel_x5(clk), .reset(reset), .enable(a_en), .in_data(a_din), .in_valid(a_val),
        .in_ready(a_rdy), .ser_out(a_so), .ser_clock(a_sc), .word_start(a_ws),
        .underrun(a_ur), .underrun_count(a_ucnt)
    );

    serializer_ddr_stream #(
        .NUM_CHANNELS(1), .WORD_WIDTH(8), .DDR(1'b0), .LSB_FIRST(1'b0),
        .CLOCK_PATTERN(8'b00001111), .IDLE_WORD(8'h3C), .REPEAT_ON_UNDERRUN(1'b1)
    ) dut_b (
        .clk_pixel_x5(clk), .reset(reset), .enable(b_en), .in_data(b_din), .in_valid(b_val),
        .in_ready(b_rdy), .ser_out(b_so), .ser_clock(b_sc), .word_start(b_ws),
        .underrun(b_ur), .underrun_count(b_ucnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [29:0] d);
        beat_t e;
        for (int g = 0; g < 5; g++) begin
            e.so = {d[20+2*g +: 2], d[10+2*g +: 2], d[2*g +: 2]};
            e.sc = cp[2*g +: 2];
            e.ws = (g == 0);
            qa.push_back(e);
        end
    endtask

    // Advance to the next falling edge and score DUT A's outputs for that cycle.
    task automatic cyc();
        beat_t e;
        @(negedge clk);
        if (a_ur) begin
            a_upulse++;
            chk("ur_with_ws", 32'(a_ws), 1);
        end
        if (!a_rdy) lowrun++;
        else begin
            if (track && lowrun > maxrun) maxrun = lowrun;
            lowrun = 0;
        end
        if (a_ws) begin
            chk("ws_gap", 32'(a_left), 0);
            a_left = 5;
        end
        if (a_left > 0) begin
            chk("q_avail", 32'(qa.size() > 0), 1);
            e = '0;
            if (qa.size() > 0) e = qa.pop_front();
            chk("a_beat", 32'({a_so, a_sc, a_ws}), 32'(e));
            a_left--;
        end else chk("a_quiet", 32'({a_so, a_sc, a_ws}), 0);
    endtask

    task automatic send_a(input logic [29:0] d);
        a_din = d;
        a_val = 1'b1;
        for (int k = 0; k < 40 && !a_rdy; k++) cyc();
        chk("send_ready", 32'(a_rdy), 1);
        push_a(d);
        cyc();
        a_val = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_rdy", 32'(a_rdy), 1);
        chk("rst_so", 32'(a_so), 0);
        chk("rst_sc", 32'(a_sc), 0);
        chk("rst_ur", 32'(a_ur), 0);
        chk("rst_cnt", 32'(a_ucnt), 0);
        chk("rst_b_rdy", 32'(b_rdy), 1);
        reset = 1'b0;
        cyc();
        chk("post_rst_rdy", 32'(a_rdy), 1);

        // SDR, MSB first, 8-bit word; second slot repeats it on underrun
        b_din = 8'hA5;
        b_val = 1'b1;
        b_en = 1'b1;
        cyc();
        b_val = 1'b0;
        chk("b_lat_ws", 32'(b_ws), 0);
        chk("b_lat_rdy", 32'(b_rdy), 0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("b_bit", 32'(b_so), 32'(b_seq[7 - i % 8]));
            chk("b_clk", 32'(b_sc), 32'(b_cseq[7 - i % 8]));
            chk("b_ws", 32'(b_ws), 32'(i % 8 == 0));
            chk("b_ur", 32'(b_ur), 32'(i == 8));
            if (i == 8) b_en = 1'b0;
        end
        cyc();
        chk("b_stop_so", 32'(b_so), 0);
        chk("b_ucnt", 32'(b_ucnt), 1);

        // Single word: lane 0 pairs and clock pairs against the literal table
        a_en = 1'b1;
        send_a({10'h0F3, 10'h2AB, 10'b1101010100});
        chk("t1_rdy_low", 32'(a_rdy), 0);
        chk("t1_ws_early", 32'(a_ws), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t1_lane0", 32'(a_so[1:0]), 32'(t1_so[9-2*i -: 2]));
            chk("t1_clk", 32'(a_sc), 32'(t1_sc[9-2*i -: 2]));
            chk("t1_ws", 32'(a_ws), 32'(i == 0));
            a_en = 1'b0;
        end
        repeat (3) cyc();

        // 100 back-to-back words
        a_en = 1'b1;
        track = 1'b1;
        for (int w = 0; w < 100; w++) send_a(30'($urandom()));
        track = 1'b0;
        chk("bulk_no_ur", 32'(a_upulse), 0);
        chk("bulk_cnt", 32'(a_ucnt), 0);
        chk("rdy_low_max", 32'(maxrun), 4);

        // Starve: three idle-word slots, then stop
        for (int k = 0; k < 3; k++) push_a({idle_w, idle_w, idle_w});
        for (int k = 0; k < 200 && a_upulse < 3; k++) cyc();
        a_en = 1'b0;
        repeat (10) cyc();
        chk("ur_pulses", 32'(a_upulse), 3);
        chk("ur_count", 32'(a_ucnt), 3);
        chk("ur_q_drained", 32'(qa.size()), 0);

        // Drop enable mid-word with the hold full, then re-enable
        a_en = 1'b1;
        send_a(30'h1234_5678);
        send_a(30'h0ABC_DEF1);
        cyc();
        a_en = 1'b0;
        repeat (8) cyc();
        chk("hold_kept", 32'(a_rdy), 0);
        a_en = 1'b1;
        cyc();
        chk("reen_ws", 32'(a_ws), 1);
        a_en = 1'b0;
        repeat (6) cyc();
        chk("reen_q", 32'(qa.size()), 0);
        chk("reen_ur", 32'(a_upulse), 3);

        // Asynchronous reset in the middle of a word with the hold full
        a_en = 1'b1;
        send_a(30'h3FFF_FFFF);
        send_a(30'h0155_5555);
        cyc();
        cyc();
        chk("pre_rst_so", 32'(a_so), 32'h3F);
        #2 reset = 1'b1;
        #1;
        chk("arst_so", 32'(a_so), 0);
        chk("arst_sc", 32'(a_sc), 0);
        chk("arst_rdy", 32'(a_rdy), 1);
        chk("arst_cnt", 32'(a_ucnt), 0);
        qa.delete();
        a_left = 0;
        a_en = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        a_en = 1'b1;
        send_a(30'h2A0F_3C5A);
        chk("rerun_ws_early", 32'(a_ws), 0);
        cyc();
        chk("rerun_ws", 32'(a_ws), 1);
        a_en = 1'b0;
        repeat (6) cyc();
        chk("q_end", 32'(qa.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
